data_mem_seq: RTL and testbench
===============================

Name: data_mem_seq

Overview:
- Parametrised single-pointer data memory for the CSE141L core: W-bit words, 2**D deep, combinational or registered read.
- Replaces the old loop-in-reset preload with a sequential init engine. After reset it clears a programmable address range one word per cycle, then writes two preset constants.
- Exposes Busy/InitDone so the core stalls until memory is valid.
- InitReq lets software re-run initialisation without a reset.

Parameters:
- W, 8, data width in bits
- D, 8, address width; depth = 2**D
- RD_LAT, 0, read latency: 0 = combinational read, 1 = registered read
- CLR_LO, 128, first address cleared by init sequence
- CLR_HI, 255, last address cleared (inclusive)
- CLR_VAL, 0, W-bit value written during clear
- PRE_A0, 16, first preset address; PRE_V0, 254, its value
- PRE_A1, 244, second preset address; PRE_V1, 5, its value

Ports:
- Clk  in  1  clock; all state changes on posedge
- Reset_n  in  1  synchronous active-low reset
- WriteEn  in  1  write strobe for DataAddress/DataIn
- DataAddress  in  D  shared read/write pointer
- DataIn  in  W  write data
- InitReq  in  1  one-cycle pulse; re-runs init sequence
- DataOut  out  W  read data
- Busy  out  1  high while init sequence is running
- InitDone  out  1  high once a sequence has completed; cleared when a new one starts

Behaviour:
- Reset and clocking: one clock (Clk); reset is synchronous and active-low (Reset_n). Reset is sampled only on posedge Clk.
- Reset_n low at an edge:
  - state = CLEAR, ptr = CLR_LO
  - Busy = 1, InitDone = 0
  - DataOut register = 0 when RD_LAT=1
  - Memory array is NOT reset; contents are held.
- State CLEAR: each cycle with Reset_n high:
  - Core[ptr] <= CLR_VAL
  - if ptr == CLR_HI, go to PRE0; else ptr <= ptr+1
  - ptr is D bits. Termination uses the equality compare, so CLR_HI = 2**D-1 must not wrap or run forever.
- State PRE0: Core[PRE_A0] <= PRE_V0, then go to PRE1.
- State PRE1: Core[PRE_A1] <= PRE_V1, then go to READY. Presets override any cleared value at the same address.
- State READY:
  - Busy = 0, InitDone = 1
  - WriteEn=1 writes Core[DataAddress] <= DataIn at the edge.
- Sequence length: exactly N = CLR_HI-CLR_LO+3 write cycles after the first edge with Reset_n high.
  - Busy falls and InitDone rises on the edge that completes PRE1.
  - Default: N = 130.
- Busy is registered, driven by state != READY.
- Writes while Busy: external WriteEn is ignored (write dropped, no queueing). The init engine owns the write port.
- Reads while Busy: permitted; they return current array contents, possibly partially initialised.
- InitReq:
  - Sampled in READY only. Next state = CLEAR, ptr = CLR_LO, Busy = 1, InitDone = 0.
  - A simultaneous WriteEn in that same cycle is performed: READY still owns the port that cycle.
  - InitReq while Busy is ignored; the sequence does not restart.
- Reset mid-sequence: Reset_n low at any state aborts and restarts from CLR_LO. Addresses already cleared stay cleared.
- Read path, RD_LAT=0:
  - DataOut = Core[DataAddress] combinationally.
  - After a write edge, the new value is visible the same cycle.
- Read path, RD_LAT=1:
  - DataOut <= Core[DataAddress] on each posedge.
  - Read-during-write to the same address returns OLD data (read-first); new data appears one cycle later.
- Elaboration checks (assertion/$error): CLR_LO <= CLR_HI < 2**D; PRE_A0, PRE_A1 < 2**D; RD_LAT in {0,1}.

Test Plan:
- Reset timing (defaults, RD_LAT=0): Reset_n low 2 cycles, then high.
  - Busy = 1 for exactly 130 cycles; InitDone rises on edge 130.
  - Core[128..255] = 0 except Core[244] = 5; Core[16] = 254.
  - Core[0..127] are not written (pre-filled 8'hAA stays 8'hAA).
- Writes during init: WriteEn=1 to addr 200, data 8'h3C, on cycle 5 of the sequence.
  - Write dropped; Core[200] = 0 after init.
  - The same write after InitDone gives Core[200] = 8'h3C.
- Read-first (RD_LAT=1): write 8'h77 to addr 10 (old 8'h11) with DataAddress held at 10.
  - DataOut = 8'h11 the cycle after the write edge, then 8'h77 one cycle later.
  - DataOut = 0 immediately after reset.
- InitReq behaviour (READY): write 8'h55 to addr 130, then pulse InitReq.
  - Busy again for 130 cycles; Core[130] = 0 after.
  - A second InitReq pulsed mid-sequence does not extend Busy.
- Reset mid-sequence: Reset_n low at sequence cycle 60, then high.
  - Sequence restarts; Busy stays high a further 130 cycles; final contents as in the reset-timing scenario.
- Boundary parameters: D=4, CLR_LO=0, CLR_HI=15, PRE_A0=PRE_A1=15, PRE_V0=1, PRE_V1=2.
  - Ptr does not wrap; sequence is 18 cycles.
  - Core[15] = 2; Core[0..14] = 0.

Source files
------------

// File: rtl/data_mem_seq.sv
// data_mem_seq: data memory with a sequential clear/preset init engine and busy/done status
module data_mem_seq #(
    parameter int W       = 8,
    parameter int D       = 8,
    parameter int RD_LAT  = 0,
    parameter int CLR_LO  = 128,
    parameter int CLR_HI  = 255,
    parameter int CLR_VAL = 0,
    parameter int PRE_A0  = 16,
    parameter int PRE_V0  = 254,
    parameter int PRE_A1  = 244,
    parameter int PRE_V1  = 5
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         WriteEn,
    input  logic [D-1:0] DataAddress,
    input  logic [W-1:0] DataIn,
    input  logic         InitReq,
    output logic [W-1:0] DataOut,
    output logic         Busy,
    output logic         InitDone
);
    typedef enum logic [1:0] {CLEAR, PRE0, PRE1, READY} state_t;

    state_t       state_q, state_d;
    logic [D-1:0] ptr_q, ptr_d;
    logic         busy_q, done_q;
    logic         we;
    logic [D-1:0] wa;
    logic [W-1:0] wd;
    logic [W-1:0] mem [2**D];

    if (!(CLR_LO >= 0 && CLR_LO <= CLR_HI && CLR_HI < 2**D && PRE_A0 >= 0 && PRE_A0 < 2**D &&
          PRE_A1 >= 0 && PRE_A1 < 2**D && (RD_LAT == 0 || RD_LAT == 1))) begin : g_param_err
        $error("data_mem_seq: illegal parameter combination");
    end

    // Next state and write-port ownership: the init engine drives the port until READY
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        wa      = '0;
        wd      = '0;
        case (state_q)
            CLEAR: begin
                we      = 1'b1;
                wa      = ptr_q;
                wd      = W'(CLR_VAL);
                state_d = (ptr_q == D'(CLR_HI)) ? PRE0 : CLEAR;
                ptr_d   = (ptr_q == D'(CLR_HI)) ? ptr_q : ptr_q + 1'b1;
            end
            PRE0: begin
                we      = 1'b1;
                wa      = D'(PRE_A0);
                wd      = W'(PRE_V0);
                state_d = PRE1;
            end
            PRE1: begin
                we      = 1'b1;
                wa      = D'(PRE_A1);
                wd      = W'(PRE_V1);
                state_d = READY;
            end
            default: begin
                we      = WriteEn;
                wa      = DataAddress;
                wd      = DataIn;
                state_d = InitReq ? CLEAR : READY;
                ptr_d   = InitReq ? D'(CLR_LO) : ptr_q;
            end
        endcase
    end

    // Engine state and registered status flags, restarted by reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= CLEAR;
            ptr_q   <= D'(CLR_LO);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= (state_d != READY);
            done_q  <= (state_d == READY);
        end
    end

    // Storage array; contents survive reset, no write happens while reset is held
    always_ff @(posedge Clk) begin
        if (Reset_n && we)
            mem[wa] <= wd;
    end

    if (RD_LAT == 0) begin : g_comb_rd
        assign DataOut = mem[DataAddress];
    end else begin : g_reg_rd
        logic [W-1:0] rd_q;
        // Registered read returns pre-write contents on a same-address collision
        always_ff @(posedge Clk) begin
            if (!Reset_n)
                rd_q <= '0;
            else
                rd_q <= mem[DataAddress];
        end
        assign DataOut = rd_q;
    end

    assign Busy     = busy_q;
    assign InitDone = done_q;
endmodule

// File: tb/tb_data_mem_seq.sv
// tb_data_mem_seq: directed checks of init timing, write blocking, read-first and restart behaviour
module tb_data_mem_seq;
    logic       Clk = 1'b0;
    logic       Reset_n, WriteEn, InitReq;
    logic [7:0] DataAddress, DataIn;
    logic [7:0] out0, out1, outb;
    logic       busy0, done0, busy1, done1, busyb, doneb;
    logic [7:0] ref_mem [256];
    int         vectors = 0, miscompares = 0, n, nb;

    always #5 Clk = ~Clk;

    data_mem_seq dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .WriteEn(WriteEn), .DataAddress(DataAddress),
        .DataIn(DataIn), .InitReq(InitReq), .DataOut(out0), .Busy(busy0), .InitDone(done0)
    );

    data_mem_seq #(.RD_LAT(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .WriteEn(WriteEn), .DataAddress(DataAddress),
        .DataIn(DataIn), .InitReq(InitReq), .DataOut(out1), .Busy(busy1), .InitDone(done1)
    );

    data_mem_seq #(.D(4), .CLR_LO(0), .CLR_HI(15), .PRE_A0(15), .PRE_V0(1), .PRE_A1(15), .PRE_V1(2)) dutb (
        .Clk(Clk), .Reset_n(Reset_n), .WriteEn(WriteEn), .DataAddress(DataAddress[3:0]),
        .DataIn(DataIn), .InitReq(InitReq), .DataOut(outb), .Busy(busyb), .InitDone(doneb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge Clk);
        WriteEn = 1'b1;
        DataAddress = 8'(a);
        DataIn = d;
        @(negedge Clk);
        WriteEn = 1'b0;
        ref_mem[a] = d;
    endtask

    // kind 1: external write to 200, kind 2: InitReq pulse, kind 3: one reset cycle
    task automatic wait_idle(input int ev, input int kind, output int cnt);
        cnt = 0;
        do begin
            @(negedge Clk);
            cnt++;
            WriteEn = 1'b0;
            InitReq = 1'b0;
            Reset_n = 1'b1;
            if (!busyb && nb == 0) nb = cnt;
            if (cnt == ev && kind == 1) begin
                WriteEn = 1'b1;
                DataAddress = 8'd200;
                DataIn = 8'h3C;
            end
            if (cnt == ev && kind == 2) InitReq = 1'b1;
            if (cnt == ev && kind == 3) Reset_n = 1'b0;
        end while ((busy0 || !Reset_n) && cnt < 1000);
    endtask

    task automatic apply_init();
        for (int a = 128; a < 256; a++) ref_mem[a] = 8'h00;
        ref_mem[16]  = 8'd254;
        ref_mem[244] = 8'd5;
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < 256; a++) begin
            @(negedge Clk);
            DataAddress = 8'(a);
            #1 chk({tag, "_comb"}, out0, ref_mem[a]);
            @(negedge Clk);
            chk({tag, "_reg"}, out1, ref_mem[a]);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        WriteEn = 1'b0;
        InitReq = 1'b0;
        DataAddress = '0;
        DataIn = '0;
        nb = 0;
        repeat (2) @(negedge Clk);
        chk("rst_busy", busy0, 1);
        chk("rst_done", done0, 0);
        chk("rst_rd1", out1, 0);
        chk("rst_bbusy", busyb, 1);
        Reset_n = 1'b1;
        wait_idle(0, 0, n);
        chk("init_len", n, 130);
        chk("init_done", done0, 1);
        chk("init_busy1", busy1, 0);
        chk("b_len", nb, 18);
        chk("b_done", doneb, 1);
        for (int a = 0; a < 16; a++) begin
            @(negedge Clk);
            DataAddress = 8'(a);
            #1 chk("b_mem", outb, (a == 15) ? 2 : 0);
        end
        for (int a = 0; a < 128; a++) wr(a, 8'hAA);
        wr(10, 8'h11);
        @(negedge Clk);
        DataAddress = 8'd10;
        WriteEn = 1'b1;
        DataIn = 8'h77;
        @(negedge Clk);
        WriteEn = 1'b0;
        chk("rf_old", out1, 8'h11);
        chk("rf_comb", out0, 8'h77);
        @(negedge Clk);
        chk("rf_new", out1, 8'h77);
        ref_mem[10] = 8'h77;
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst2_rd1", out1, 0);
        Reset_n = 1'b1;
        wait_idle(100, 1, n);
        chk("drop_len", n, 130);
        apply_init();
        check_mem("after_drop");
        wr(200, 8'h3C);
        #1 chk("wr_ready", out0, 8'h3C);
        wr(130, 8'h55);
        #1 chk("wr_130", out0, 8'h55);
        @(negedge Clk);
        WriteEn = 1'b1;
        DataAddress = 8'd20;
        DataIn = 8'h66;
        InitReq = 1'b1;
        ref_mem[20] = 8'h66;
        @(negedge Clk);
        WriteEn = 1'b0;
        InitReq = 1'b0;
        chk("req_busy", busy0, 1);
        chk("req_done", done0, 0);
        wait_idle(60, 2, n);
        chk("req_len", n, 130);
        chk("req_done2", done0, 1);
        apply_init();
        check_mem("after_req");
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        wait_idle(60, 3, n);
        chk("midrst_len", n, 191);
        apply_init();
        check_mem("after_midrst");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
